// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester-side request/response bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [NUM_REQ*DATA_W-1:0] resp_data;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter for a 2-read/1-write memory; optional MEM_ARB_RAW_BYPASS_EN forwards same-cycle write data to reads
module mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      req_if,
    output logic [ADDR_W-1:0] mem_read0_o,
    output logic [ADDR_W-1:0] mem_read1_o,
    input  logic [DATA_W-1:0] mem_out0_i,
    input  logic [DATA_W-1:0] mem_out1_i,
    output logic              mem_writing_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic               p0_vld_q, p0_vld_d, p1_vld_q, p1_vld_d;
    logic [ID_W-1:0]    p0_id_q, p0_id_d, p1_id_q, p1_id_d;
    logic               rd0_hit, rd1_hit, wr_hit;
    logic [ID_W-1:0]    rd0_id, rd1_id, wr_id, rd_cand, wr_cand;
    logic [NUM_REQ-1:0] rd_req, wr_req;
    logic [DATA_W-1:0]  p0_data, p1_data;

    assign rd_req = req_if.req_valid & ~req_if.req_write;
    assign wr_req = req_if.req_valid &  req_if.req_write;

    // Rotating scan: the first two readers and the first writer after each pointer win.
    always_comb begin
        rd0_hit = 1'b0;
        rd1_hit = 1'b0;
        wr_hit  = 1'b0;
        rd0_id  = '0;
        rd1_id  = '0;
        wr_id   = '0;
        rd_cand = '0;
        wr_cand = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rd_cand = ID_W'((int'(rd_ptr_q) + k) % NUM_REQ);
            wr_cand = ID_W'((int'(wr_ptr_q) + k) % NUM_REQ);
            if (rd_req[rd_cand]) begin
                if (!rd0_hit) begin
                    rd0_hit = 1'b1;
                    rd0_id  = rd_cand;
                end else if (!rd1_hit) begin
                    rd1_hit = 1'b1;
                    rd1_id  = rd_cand;
                end
            end
            if (wr_req[wr_cand] && !wr_hit) begin
                wr_hit = 1'b1;
                wr_id  = wr_cand;
            end
        end
    end

    always_comb begin
        req_if.req_ready = '0;
        mem_read0_o      = '0;
        mem_read1_o      = '0;
        mem_writing_o    = 1'b0;
        mem_waddr_o      = '0;
        mem_wdata_o      = '0;
        if (!rst) begin
            if (rd0_hit) begin
                req_if.req_ready[rd0_id] = 1'b1;
                mem_read0_o = req_if.req_addr[int'(rd0_id)*ADDR_W +: ADDR_W];
            end
            if (rd1_hit) begin
                req_if.req_ready[rd1_id] = 1'b1;
                mem_read1_o = req_if.req_addr[int'(rd1_id)*ADDR_W +: ADDR_W];
            end
            if (wr_hit) begin
                req_if.req_ready[wr_id] = 1'b1;
                mem_writing_o = 1'b1;
                mem_waddr_o   = req_if.req_addr[int'(wr_id)*ADDR_W +: ADDR_W];
                mem_wdata_o   = req_if.req_wdata[int'(wr_id)*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (rd1_hit) begin
            rd_ptr_d = ID_W'((int'(rd1_id) + 1) % NUM_REQ);
        end else if (rd0_hit) begin
            rd_ptr_d = ID_W'((int'(rd0_id) + 1) % NUM_REQ);
        end
        if (wr_hit) begin
            wr_ptr_d = ID_W'((int'(wr_id) + 1) % NUM_REQ);
        end
        p0_vld_d = rd0_hit;
        p0_id_d  = rd0_id;
        p1_vld_d = rd1_hit;
        p1_id_d  = rd1_id;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            p0_vld_q <= 1'b0;
            p1_vld_q <= 1'b0;
            p0_id_q  <= '0;
            p1_id_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            p0_vld_q <= p0_vld_d;
            p1_vld_q <= p1_vld_d;
            p0_id_q  <= p0_id_d;
            p1_id_q  <= p1_id_d;
        end
    end

`ifdef MEM_ARB_RAW_BYPASS_EN
    // The memory reads before it writes, so a same-address read must take the write data instead.
    logic              byp0_q, byp1_q;
    logic [DATA_W-1:0] byp_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp0_q     <= 1'b0;
            byp1_q     <= 1'b0;
            byp_data_q <= '0;
        end else begin
            byp0_q     <= rd0_hit && wr_hit && (mem_read0_o == mem_waddr_o);
            byp1_q     <= rd1_hit && wr_hit && (mem_read1_o == mem_waddr_o);
            byp_data_q <= mem_wdata_o;
        end
    end

    assign p0_data = byp0_q ? byp_data_q : mem_out0_i;
    assign p1_data = byp1_q ? byp_data_q : mem_out1_i;
`else
    assign p0_data = mem_out0_i;
    assign p1_data = mem_out1_i;
`endif

    always_comb begin
        req_if.resp_valid = '0;
        req_if.resp_data  = '0;
        if (p0_vld_q) begin
            req_if.resp_valid[p0_id_q] = 1'b1;
            req_if.resp_data[int'(p0_id_q)*DATA_W +: DATA_W] = p0_data;
        end
        if (p1_vld_q) begin
            req_if.resp_valid[p1_id_q] = 1'b1;
            req_if.resp_data[int'(p1_id_q)*DATA_W +: DATA_W] = p1_data;
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the two read ports and single write port of the 64K x 32-bit core memory among NUM_REQ requesters (GPU cores / load-store units).
- Round-robin arbitration with per-requester valid/ready handshake.
- Tracks the memory's 1-cycle registered read latency and routes each read response back to the requester that issued it.
- Sits between the cores and the memory; drives the memory's read0/read1/writing/waddr/wdata inputs.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ADDR_W, 16, address width; must match the memory.
- DATA_W, 32, data width; must match the memory.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a request this cycle.
- req_write  in  NUM_REQ  1 = write, 0 = read, per requester.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  combinational grant; a transfer happens when valid & ready are high at a posedge.
- resp_valid  out  NUM_REQ  registered; read data for requester i is present this cycle.
- resp_data  out  NUM_REQ*DATA_W  packed read data; valid only where resp_valid is set.
- mem_read0  out  ADDR_W  to memory read port 0.
- mem_read1  out  ADDR_W  to memory read port 1.
- mem_out0  in  DATA_W  from memory port 0; registered in the memory.
- mem_out1  in  DATA_W  from memory port 1.
- mem_writing  out  1  memory write enable.
- mem_waddr  out  ADDR_W  memory write address.
- mem_wdata  out  DATA_W  memory write data.

Behaviour:
- Reset values (rst high, asynchronous):
  - rd_ptr = 0, wr_ptr = 0, both response-pipeline valid bits = 0.
  - resp_valid = 0, resp_data = 0.
  - req_ready = 0, mem_writing = 0 (combinationally forced while rst is high).
  - mem_read0, mem_read1, mem_waddr and mem_wdata = 0.
- Read arbitration (combinational, per cycle):
  - Scan requesters i = rd_ptr, rd_ptr+1, ... mod NUM_REQ for valid & ~write.
  - First hit gets port 0: mem_read0 = its address, its req_ready = 1.
  - Second hit gets port 1: mem_read1 = its address, its req_ready = 1.
  - No further read grants that cycle.
  - Unused read ports drive address 0.
- Write arbitration (independent of reads):
  - Scan from wr_ptr for valid & write; the first hit is granted.
  - On a grant: mem_writing = 1, mem_waddr and mem_wdata = that requester's values, req_ready = 1.
  - Otherwise mem_writing = 0.
- A requester presents one request per cycle. A read and a write from different requesters proceed in the same cycle.
- Pointer update at posedge, only on a grant:
  - rd_ptr <= (index of last read granted + 1) mod NUM_REQ.
  - wr_ptr <= (write winner + 1) mod NUM_REQ.
  - With no grant, the pointer holds.
- Read latency:
  - A read accepted in cycle t is registered as (valid, requester id) per port.
  - In cycle t+1: resp_valid[id] = 1 and resp_data[id] = mem_out0 or mem_out1, matching the port used.
  - Fixed latency of exactly 1 cycle. There is no response backpressure; requesters must always accept.
  - Back-to-back reads from the same requester give back-to-back responses.
  - Ports 0 and 1 never both target the same requester in one cycle.
- Same-address hazard (macro absent): a read and a write to the same address accepted in the same cycle return the OLD data, matching the memory's read-before-write.
- A write accepted in cycle t is visible to reads accepted in cycle t+1 or later.
- Reset asserted mid-operation clears in-flight responses; their data is dropped and no resp_valid appears after reset release.
- Starvation bound: a waiting read is granted within ceil(NUM_REQ/2) cycles; a waiting write within NUM_REQ cycles.

Optional Feature:
- Macro: MEM_ARB_RAW_BYPASS_EN.
- Defined:
  - When a read on port p and the granted write share an address in the same cycle, the arbiter registers a bypass flag and the write data.
  - In cycle t+1 resp_data returns the new write data instead of mem_out_p.
  - Reads always see all writes accepted in the same cycle or earlier.
- Undefined: no bypass logic; old-data behaviour as above.

Test Plan:
- Reset: hold rst with all req_valid = 1 -> req_ready = 0, mem_writing = 0, resp_valid = 0. Release rst -> grants start with rd_ptr = wr_ptr = 0.
- Single write then read: req 2 writes 0xDEADBEEF to 0x0010 in cycle t; req 2 reads 0x0010 in cycle t+1 -> resp_valid[2] = 1 and resp_data = 0xDEADBEEF in cycle t+2.
- Three readers: reqs 0, 1, 3 read 0x0001 / 0x0002 / 0x0003 (preloaded 0x11 / 0x22 / 0x33), held valid.
  - Cycle 0: reqs 0 and 1 granted, rd_ptr -> 2.
  - Cycle 1: reqs 3 and 0 granted; responses are 0x11 and 0x22 in cycle 1.
  - Req 1's second read is granted in cycle 2.
- Write contention: all 4 requesters issue writes continuously -> grant order 0, 1, 2, 3, 0; exactly one mem_writing per cycle.
- Same-cycle hazard: req 0 writes 0x5 to 0x0100 (old value 0x9) while req 1 reads 0x0100 -> resp_data[1] = 0x9 without the macro, 0x5 with MEM_ARB_RAW_BYPASS_EN.
- Mid-flight reset: read accepted in cycle t, rst pulsed asynchronously before the next posedge -> resp_valid stays 0 and no stale response after release.
